// File: rtl/chess_timer_pkg.sv
// Shared constants and types for the chess-timer datapath.
package chess_timer_pkg;

  localparam int DEF_CLK_HZ    = 50_000_000;
  localparam int DEF_TICK_HZ   = 1;
  localparam int DEF_WIDTH     = 10;
  localparam int DEF_INIT_TIME = 300;
  localparam int DEF_INCREMENT = 5;

  localparam int P1          = 0;
  localparam int P2          = 1;
  localparam int NUM_PLAYERS = 2;

  typedef logic [DEF_WIDTH-1:0] cnt_t;

endpackage

// File: rtl/chess_clock_counters_tick_gen.sv
// Prescaler producing a one-cycle registered tick every CLK_HZ/TICK_HZ enabled cycles.
module tick_gen
  import chess_timer_pkg::*;
#(
  parameter int CLK_HZ  = DEF_CLK_HZ,
  parameter int TICK_HZ = DEF_TICK_HZ
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_en,
  input  logic i_clr,
  output logic o_tick
);

  localparam int PERIOD = CLK_HZ / TICK_HZ;
  localparam int PW     = $clog2(PERIOD);
  localparam logic [PW-1:0] TC_V   = PW'(PERIOD - 1);
  localparam logic [PW-1:0] ZERO_V = {PW{1'b0}};
  localparam logic [PW-1:0] ONE_V  = PW'(1);

  logic [PW-1:0] r_cnt;
  logic          r_tick;

  // Prescaler count and tick pulse; clear wins so a new turn restarts a full period.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt  <= ZERO_V;
      r_tick <= 1'b0;
    end else if (i_clr) begin
      r_cnt  <= ZERO_V;
      r_tick <= 1'b0;
    end else if (i_en) begin
      if (r_cnt == TC_V) begin
        r_cnt  <= ZERO_V;
        r_tick <= 1'b1;
      end else begin
        r_cnt  <= r_cnt + ONE_V;
        r_tick <= 1'b0;
      end
    end else begin
      r_tick <= 1'b0;
    end
  end

  assign o_tick = r_tick;

endmodule

// File: rtl/chess_clock_counters.sv
// Per-player saturating countdown counters driven by the chess-timer FSM strobes.
// Optional Fischer increment on handover is enabled by defining CHESS_INCREMENT_EN.
module chess_clock_counters
  import chess_timer_pkg::*;
#(
  parameter int CLK_HZ    = DEF_CLK_HZ,
  parameter int TICK_HZ   = DEF_TICK_HZ,
  parameter int WIDTH     = $bits(cnt_t),
  parameter int INIT_TIME = DEF_INIT_TIME,
  parameter int INCREMENT = DEF_INCREMENT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       load_counters,
  input  logic [1:0]       en_counters,
  output logic [WIDTH-1:0] counter_1,
  output logic [WIDTH-1:0] counter_2,
  output logic [1:0]       zero,
  output logic             tick
);

  localparam logic [WIDTH-1:0] INIT_V = WIDTH'(INIT_TIME);
  localparam logic [WIDTH-1:0] ZERO_V = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] ONE_V  = WIDTH'(1);

  if ((CLK_HZ / TICK_HZ) < 2 || INIT_TIME >= (1 << WIDTH) || INCREMENT < 0) begin : g_param_check
    $error("chess_clock_counters: invalid parameter set");
  end

  logic [1:0] r_en_prev;
  logic       w_run;
  logic       w_clr;
  logic       w_tick;

  assign w_run = |en_counters;
  assign w_clr = ~w_run | (en_counters != r_en_prev);

  // Previous-cycle enables, used to detect turn switches and handovers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_en_prev <= 2'b00;
    end else begin
      r_en_prev <= en_counters;
    end
  end

  tick_gen #(
    .CLK_HZ (CLK_HZ),
    .TICK_HZ(TICK_HZ)
  ) u_tick_gen (
    .clk   (clk),
    .rst_n (reset),
    .i_en  (w_run),
    .i_clr (w_clr),
    .o_tick(w_tick)
  );

  assign tick = w_tick;

`ifdef CHESS_INCREMENT_EN
  localparam logic [WIDTH:0]   BONUS_V = (WIDTH + 1)'(INCREMENT);
  localparam logic [WIDTH-1:0] MAX_V   = {WIDTH{1'b1}};

  logic [1:0] r_load_prev;
  logic [1:0] w_load_rise;

  function automatic logic [WIDTH-1:0] sat_add_bonus(input logic [WIDTH-1:0] val);
    logic [WIDTH:0] sum;
    sum = {1'b0, val} + BONUS_V;
    return sum[WIDTH] ? MAX_V : sum[WIDTH-1:0];
  endfunction

  // Registered copy of the load strobes for rising-edge detection.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_load_prev <= 2'b00;
    end else begin
      r_load_prev <= load_counters;
    end
  end

  assign w_load_rise = load_counters & ~r_load_prev;
`endif

  for (genvar p = P1; p <= P2; p++) begin : g_player
    logic [WIDTH-1:0] r_cnt;
    logic [WIDTH-1:0] w_next;
    logic             w_dec;

    assign w_dec = en_counters[p] & w_tick & (r_cnt != ZERO_V);

    // Next count: load beats decrement, and the count never goes below zero.
    always_comb begin
      w_next = r_cnt;
`ifdef CHESS_INCREMENT_EN
      if (w_load_rise[p]) begin
        if (r_en_prev[p]) begin
          if (r_cnt != ZERO_V) begin
            w_next = sat_add_bonus(r_cnt);
          end else begin
            w_next = r_cnt;
          end
        end else begin
          w_next = INIT_V;
        end
      end else if (w_dec) begin
        w_next = r_cnt - ONE_V;
      end else begin
        w_next = r_cnt;
      end
`else
      if (load_counters[p]) begin
        w_next = INIT_V;
      end else if (w_dec) begin
        w_next = r_cnt - ONE_V;
      end else begin
        w_next = r_cnt;
      end
`endif
    end

    // Counter state register.
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        r_cnt <= INIT_V;
      end else begin
        r_cnt <= w_next;
      end
    end

    assign zero[p] = (r_cnt == ZERO_V);
  end

  assign counter_1 = g_player[P1].r_cnt;
  assign counter_2 = g_player[P2].r_cnt;

endmodule
